// File: rtl/demux_stream_if.sv
// Bus bundle for demux_stream: upstream beat, shared payload, per-channel valid/ready and status.
// master drives the block's inputs (producer/consumer side); slave is the demux itself.
interface demux_stream_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned SELW  = 2
) ();
   logic             mode;
   logic [SELW-1:0]  sel;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic [N-1:0]     out_valid;
   logic [WIDTH-1:0] out_data;
   logic [N-1:0]     out_ready;
   logic [SELW-1:0]  rr_ptr;
   logic [7:0]       drop_cnt;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, rr_ptr, drop_cnt
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, rr_ptr, drop_cnt
   );
endinterface

// File: rtl/demux_stream.sv
// One-deep stream demultiplexer: routes each accepted beat to one of N channels,
// either by sel (addressed) or by a round-robin pointer; out-of-range sel beats are counted and dropped.
module demux_stream #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4,
   parameter int unsigned SELW  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   demux_stream_if.slave   bus
);

   localparam int unsigned DROPW = 8;

   logic [N-1:0]     out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;
   logic [DROPW-1:0] drop_cnt_q,  drop_cnt_d;

   logic             held_c;
   logic             deliver_c;
   logic             in_ready_c;
   logic             accept_c;
   logic             sel_oob_c;
   logic [SELW-1:0]  dest_c;

   // Handshake decode; only the held channel's ready can release the slot.
   always_comb begin
      held_c     = |out_valid_q;
      deliver_c  = |(out_valid_q & bus.out_ready);
      in_ready_c = !held_c || deliver_c;
      accept_c   = bus.in_valid && in_ready_c;
      dest_c     = bus.mode ? rr_ptr_q : bus.sel;
      sel_oob_c  = !bus.mode && (32'(bus.sel) >= 32'(N));
   end

   // Next-state: delivery empties the slot, a same-edge accept refills it without a bubble.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rr_ptr_d    = rr_ptr_q;
      drop_cnt_d  = drop_cnt_q;

      if (deliver_c) begin
         out_valid_d = '0;
      end

      if (accept_c) begin
         if (sel_oob_c) begin
            if (drop_cnt_q != {DROPW{1'b1}}) begin
               drop_cnt_d = drop_cnt_q + DROPW'(1);
            end
         end else begin
            out_valid_d = N'(1) << dest_c;
            out_data_d  = bus.in_data;
         end

         if (bus.mode) begin
            rr_ptr_d = (rr_ptr_q == SELW'(N - 1)) ? '0 : rr_ptr_q + SELW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= '0;
         out_data_q  <= '0;
         rr_ptr_q    <= '0;
         drop_cnt_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         rr_ptr_q    <= rr_ptr_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // in_ready is a combinational pass-through so a ready consumer sees full throughput.
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.rr_ptr    = rr_ptr_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed scenarios plus random traffic, scored against a queue-based model.
module tb_demux_stream;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   demux_stream_if #(.WIDTH(8), .N(4), .SELW(2)) bus ();
   demux_stream_if #(.WIDTH(8), .N(3), .SELW(2)) bus3 ();

   demux_stream #(.WIDTH(8), .N(4), .SELW(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   demux_stream #(.WIDTH(8), .N(3), .SELW(2)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else passes++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic m, input logic [1:0] s, input logic v,
                        input logic [7:0] d, input logic [3:0] r);
      bus.mode      = m;
      bus.sel       = s;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
   endtask

   task automatic drive3(input logic m, input logic [1:0] s, input logic v,
                         input logic [7:0] d, input logic [2:0] r);
      bus3.mode      = m;
      bus3.sel       = s;
      bus3.in_valid  = v;
      bus3.in_data   = d;
      bus3.out_ready = r;
   endtask

   // Reference model for the N=4 instance: a queue of beats awaiting delivery.
   typedef struct {
      int         ch;
      logic [7:0] data;
   } beat_t;

   beat_t      pend[$];
   int         rr_m   = 0;
   int         drop_m = 0;
   logic [7:0] last_m = 8'h00;

   always @(negedge clk) begin : monitor
      logic [3:0] exp_ov;
      logic       exp_rdy;
      beat_t      b;
      if (!rst_n) begin
         pend.delete();
         rr_m   = 0;
         drop_m = 0;
         last_m = 8'h00;
         chk("mon_rst_ov", 32'(bus.out_valid), 32'h0);
         chk("mon_rst_ir", 32'(bus.in_ready), 32'h1);
      end else begin
         exp_ov  = 4'b0000;
         exp_rdy = 1'b1;
         if (pend.size() != 0) begin
            exp_ov  = 4'(1 << pend[0].ch);
            exp_rdy = bus.out_ready[pend[0].ch];
         end
         chk("mon_out_valid", 32'(bus.out_valid), 32'(exp_ov));
         chk("mon_out_data", 32'(bus.out_data), 32'(last_m));
         chk("mon_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         chk("mon_rr_ptr", 32'(bus.rr_ptr), 32'(rr_m));
         chk("mon_drop_cnt", 32'(bus.drop_cnt), 32'(drop_m));

         if (pend.size() != 0 && bus.out_ready[pend[0].ch]) void'(pend.pop_front());

         if (bus.in_valid && exp_rdy) begin
            if (!bus.mode && int'(bus.sel) >= 4) begin
               drop_m = (drop_m >= 255) ? 255 : drop_m + 1;
            end else begin
               b.ch   = bus.mode ? rr_m : int'(bus.sel);
               b.data = bus.in_data;
               pend.push_back(b);
               last_m = bus.in_data;
            end
            if (bus.mode) rr_m = (rr_m + 1) % 4;
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      drive3(1'b0, 2'd0, 1'b0, 8'h00, 3'h0);
      repeat (2) tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_rr_ptr", 32'(bus.rr_ptr), 32'h0);
      chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

      // Single addressed beat to channel 2, accepted on the first edge after reset release.
      rst_n = 1'b1;
      drive(1'b0, 2'd2, 1'b1, 8'hA5, 4'hF);
      tick();
      chk("addr_ov", 32'(bus.out_valid), 32'h4);
      chk("addr_od", 32'(bus.out_data), 32'hA5);
      drive(1'b0, 2'd2, 1'b0, 8'h00, 4'hF);
      tick();
      chk("addr_ov_clear", 32'(bus.out_valid), 32'h0);
      chk("addr_od_keep", 32'(bus.out_data), 32'hA5);

      // Six back-to-back round-robin beats.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 2'd0, 1'b1, 8'(8'h10 + i), 4'hF);
         tick();
         chk("rr_ov", 32'(bus.out_valid), 32'(1 << (i % 4)));
         chk("rr_od", 32'(bus.out_data), 32'(8'h10 + i));
      end
      chk("rr_ptr_end", 32'(bus.rr_ptr), 32'h2);
      drive(1'b1, 2'd0, 1'b0, 8'h00, 4'hF);
      tick();

      // Backpressure on channel 1; ready on channel 0 must not release it.
      drive(1'b0, 2'd1, 1'b1, 8'h3C, 4'b0001);
      tick();
      drive(1'b0, 2'd0, 1'b1, 8'h77, 4'b0001);
      for (int k = 0; k < 3; k++) begin
         chk("stall_ir", 32'(bus.in_ready), 32'h0);
         chk("stall_ov", 32'(bus.out_valid), 32'h2);
         chk("stall_od", 32'(bus.out_data), 32'h3C);
         tick();
      end
      bus.out_ready = 4'b0011;
      #1;
      chk("release_ir", 32'(bus.in_ready), 32'h1);
      tick();
      chk("replace_ov", 32'(bus.out_valid), 32'h1);
      chk("replace_od", 32'(bus.out_data), 32'h77);
      drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
      tick();

      // Mode switch: rr_ptr held across an addressed beat.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'd0, 1'b1, 8'(8'h20 + i), 4'hF);
         tick();
      end
      chk("mode_rr1", 32'(bus.rr_ptr), 32'h1);
      drive(1'b0, 2'd3, 1'b1, 8'h31, 4'hF);
      tick();
      chk("mode_addr_ov", 32'(bus.out_valid), 32'h8);
      chk("mode_rr_hold", 32'(bus.rr_ptr), 32'h1);
      drive(1'b1, 2'd3, 1'b1, 8'h32, 4'hF);
      tick();
      chk("mode_rr_ov", 32'(bus.out_valid), 32'h2);
      chk("mode_rr_adv", 32'(bus.rr_ptr), 32'h2);
      drive(1'b1, 2'd0, 1'b0, 8'h00, 4'hF);
      tick();

      // Asynchronous reset while channel 3 is held and rr_ptr=3.
      drive(1'b1, 2'd0, 1'b1, 8'h40, 4'hF);
      tick();
      drive(1'b0, 2'd3, 1'b1, 8'h41, 4'hF);
      tick();
      drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tick();
      chk("pre_rst_ov", 32'(bus.out_valid), 32'h8);
      chk("pre_rst_rr", 32'(bus.rr_ptr), 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ov", 32'(bus.out_valid), 32'h0);
      chk("async_rst_rr", 32'(bus.rr_ptr), 32'h0);
      chk("async_rst_drop", 32'(bus.drop_cnt), 32'h0);
      chk("async_rst_od", 32'(bus.out_data), 32'h0);
      chk("async_rst_ir", 32'(bus.in_ready), 32'h1);
      tick();
      drive(1'b1, 2'd0, 1'b1, 8'h50, 4'hF);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ov", 32'(bus.out_valid), 32'h1);
      chk("post_rst_od", 32'(bus.out_data), 32'h50);

      // Random traffic against the model.
      repeat (1500) begin
         drive(1'($urandom), 2'($urandom), ($urandom_range(0, 9) < 7),
               8'($urandom), 4'($urandom));
         tick();
      end
      drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
      repeat (2) tick();

      // N=3 instance: out-of-range sel is dropped and the counter saturates.
      for (int i = 0; i < 300; i++) begin
         drive3(1'b0, 2'd3, 1'b1, 8'(i), 3'b111);
         tick();
         chk("n3_drop_ov", 32'(bus3.out_valid), 32'h0);
         chk("n3_drop_cnt", 32'(bus3.drop_cnt), 32'((i + 1 > 255) ? 255 : i + 1));
      end
      chk("n3_drop_rr", 32'(bus3.rr_ptr), 32'h0);
      chk("n3_drop_od", 32'(bus3.out_data), 32'h0);
      drive3(1'b0, 2'd1, 1'b1, 8'hAB, 3'b111);
      tick();
      chk("n3_addr_ov", 32'(bus3.out_valid), 32'h2);
      chk("n3_addr_od", 32'(bus3.out_data), 32'hAB);
      chk("n3_drop_sat", 32'(bus3.drop_cnt), 32'd255);
      for (int i = 0; i < 4; i++) begin
         drive3(1'b1, 2'd0, 1'b1, 8'(8'h60 + i), 3'b111);
         tick();
         chk("n3_rr_ov", 32'(bus3.out_valid), 32'(1 << (i % 3)));
      end
      chk("n3_rr_wrap", 32'(bus3.rr_ptr), 32'h1);
      drive3(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);
      tick();
      chk("n3_idle_ov", 32'(bus3.out_valid), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
